alu_seq_ctrl: RTL

Multi-cycle sequencer that wraps the 16-bit combinational ALU. It accepts one 16-bit instruction per handshake, reads operands from the synchronous-read register file, and presents them to the ALU with opcode/opext. It then writes the result back and latches the five ALU flags into a processor status register. The block sits between instruction fetch and the register file/ALU pair.

---
 rtl/alu_seq_ctrl_if.sv | 35 +++
 rtl/alu_seq_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Bundle of fetch handshake, register-file and ALU signals around alu_seq_ctrl.
// master: the sequencer; slave: fetch unit, register file and ALU side.
interface alu_seq_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  rf_raddr_a;
  logic [3:0]  rf_raddr_b;
  logic [15:0] rf_rdata_a;
  logic [15:0] rf_rdata_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_opcode;
  logic [3:0]  alu_opext;
  logic [15:0] alu_s;
  logic [4:0]  alu_flags;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [4:0]  psr;
  logic        done;
  logic        illegal;

  modport master (
    input  instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_s, alu_flags,
    output instr_ready, rf_raddr_a, rf_raddr_b, alu_a, alu_b, alu_opcode, alu_opext,
           rf_we, rf_waddr, rf_wdata, psr, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_s, alu_flags,
    input  instr_ready, rf_raddr_a, rf_raddr_b, alu_a, alu_b, alu_opcode, alu_opext,
           rf_we, rf_waddr, rf_wdata, psr, done, illegal
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Four-cycle sequencer (IDLE/READ/EXEC/WB) driving a 16-bit combinational ALU and register file.
// Define IMM_SIGN_EXT_EN to sign-extend the 8-bit I-type immediate (MOVIU always zero-extends).
module alu_seq_ctrl (
  input logic            clk,
  input logic            reset,
  alu_seq_ctrl_if.master bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StExec = 2'd2;
  localparam logic [1:0] StWb   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] instr_q;
  logic [15:0] result_q;
  logic [4:0]  flags_q;
  logic [4:0]  psr_q;

  logic [3:0]  opcode, rdest, opext, rsrc;
  logic        r_type, is_nop, legal, write_en, psr_en;
  logic [15:0] imm16, oper_a, oper_b;

  assign opcode = instr_q[15:12];
  assign rdest  = instr_q[11:8];
  assign opext  = instr_q[7:4];
  assign rsrc   = instr_q[3:0];

  always_comb begin
    r_type = (opcode == 4'h0);
    is_nop = r_type && (opext == 4'h0);
    if (r_type) begin
      unique case (opext)
        4'hA, 4'hB, 4'hF: legal = 1'b0;
        default:          legal = 1'b1;
      endcase
    end else begin
      unique case (opcode)
        4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hE: legal = 1'b1;
        default:                                         legal = 1'b0;
      endcase
    end
    // Compares (0011, 1011) only update flags; MOVIU only writes the register.
    write_en = legal && !is_nop && (opcode != 4'h3) && (opcode != 4'hB);
    psr_en   = legal && !is_nop && (opcode != 4'h7);
  end

  always_comb begin
`ifdef IMM_SIGN_EXT_EN
    imm16 = {{8{instr_q[7]}}, instr_q[7:0]};
`else
    imm16 = {8'h00, instr_q[7:0]};
`endif
    if (r_type) begin
      oper_a = bus.rf_rdata_a;
      oper_b = bus.rf_rdata_b;
    end else if (opcode == 4'h7) begin
      // MOVIU: ALU merges Rdest high byte with the raw immediate byte.
      oper_a = bus.rf_rdata_b;
      oper_b = {8'h00, instr_q[7:0]};
    end else begin
      oper_a = imm16;
      oper_b = bus.rf_rdata_b;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.instr_valid) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      instr_q  <= 16'h0000;
      result_q <= 16'h0000;
      flags_q  <= 5'b00000;
      psr_q    <= 5'b00000;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && bus.instr_valid) instr_q <= bus.instr;
      if (state_q == StExec) begin
        result_q <= bus.alu_s;
        flags_q  <= bus.alu_flags;
      end
      if ((state_q == StWb) && psr_en) psr_q <= flags_q;
    end
  end

  always_comb begin
    bus.instr_ready = (state_q == StIdle);
    bus.rf_raddr_a  = 4'h0;
    bus.rf_raddr_b  = 4'h0;
    bus.alu_a       = 16'h0000;
    bus.alu_b       = 16'h0000;
    bus.alu_opcode  = 4'h0;
    bus.alu_opext   = 4'h0;
    bus.rf_we       = 1'b0;
    bus.rf_waddr    = 4'h0;
    bus.rf_wdata    = 16'h0000;
    bus.done        = 1'b0;
    bus.illegal     = 1'b0;
    unique case (state_q)
      StRead: begin
        bus.rf_raddr_a = rsrc;
        bus.rf_raddr_b = rdest;
      end
      StExec: begin
        bus.alu_a      = oper_a;
        bus.alu_b      = oper_b;
        bus.alu_opcode = opcode;
        bus.alu_opext  = opext;
      end
      StWb: begin
        bus.rf_we    = write_en;
        bus.rf_waddr = rdest;
        bus.rf_wdata = result_q;
        bus.done     = 1'b1;
        bus.illegal  = !legal;
      end
      default: ;
    endcase
  end

  assign bus.psr = psr_q;

endmodule
